// File: rtl/rng_fetch_if.sv
// rng_fetch_if: rng start/valid handshake and downstream ready/valid stream for rng_fetch.
interface rng_fetch_if #(parameter int DEPTH = 8);
    logic                   en;
    logic                   rng_start;
    logic                   rng_valid;
    logic [31:0]            rng_data;
    logic [31:0]            m_data;
    logic                   m_valid;
    logic                   m_ready;
    logic [$clog2(DEPTH):0] level;
    modport master (input en, rng_valid, rng_data, m_ready, output rng_start, m_data, m_valid, level);
    modport slave (output en, rng_valid, rng_data, m_ready, input rng_start, m_data, m_valid, level);
endinterface

// File: rtl/rng_fetch.sv
// rng_fetch: prefetches rng words into a FIFO and streams them out as ready/valid.
// Optional RNG_FETCH_STATS_EN adds word_cnt and a sticky stall_seen flag.
module rng_fetch #(
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    rng_fetch_if.master bus
`ifdef RNG_FETCH_STATS_EN
    ,
    output logic [31:0] word_cnt,
    output logic        stall_seen
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [1:0] {WAIT_HI, REQ, WAIT_LO} state_t;

    state_t        state, state_nxt;
    logic [31:0]   mem [DEPTH];
    logic [AW:0]   wptr, rptr;
    logic          full, empty, push, pop, start_q;

    assign empty = wptr == rptr;
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    // a pop in the same cycle does not free a slot for this write
    assign push  = (state == WAIT_HI) && bus.rng_valid && !full && bus.en;
    assign pop   = !empty && bus.m_ready;

    assign bus.rng_start = start_q;
    assign bus.m_valid   = !empty;
    assign bus.m_data    = empty ? 32'd0 : mem[rptr[AW-1:0]];
    assign bus.level     = LW'(wptr - rptr);

    always_comb begin
        state_nxt = state;
        unique case (state)
            WAIT_HI: state_nxt = push ? REQ : WAIT_HI;
            REQ:     state_nxt = WAIT_LO;
            WAIT_LO: state_nxt = bus.rng_valid ? WAIT_LO : WAIT_HI;
            default: state_nxt = WAIT_HI;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= WAIT_HI;
            wptr    <= '0;
            rptr    <= '0;
            start_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            wptr    <= wptr + LW'(push);
            rptr    <= rptr + LW'(pop);
            start_q <= state_nxt == REQ;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wptr[AW-1:0]] <= bus.rng_data;
    end

`ifdef RNG_FETCH_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            word_cnt   <= '0;
            stall_seen <= 1'b0;
        end else begin
            word_cnt   <= word_cnt + 32'(push);
            stall_seen <= stall_seen | ((state == WAIT_HI) && bus.rng_valid && full);
        end
    end
`endif
endmodule
